step_pulse_gen: RTL
===================

Name: step_pulse_gen

Overview:
Motion sequencer that sits directly upstream of the 4-phase stepper coil-pattern FSM. It accepts a move command (step count, direction, step interval) and drives the FSM's enable and direction inputs. It emits exactly one single-cycle enable pulse per motor step, spaced at a programmable interval, then signals completion. It also provides abort and status outputs for the front-panel/control logic.

Parameters:
CNT_W, 16, width of the step count and remaining-steps bus
PER_W, 20, width of the step interval (clock cycles per step)
RAMP_STEPS, 4, number of slow steps at move start (used only with the optional feature)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle move request; accepted only in IDLE
abort  input  1  synchronous stop request
dir_in  input  1  requested direction; 1 = forward, 0 = reverse
step_count  input  CNT_W  number of steps to issue
period  input  PER_W  clock cycles between step pulses; 0 is treated as 1
enable  output  1  one-cycle step pulse to the coil FSM's enable input
direction  output  1  held direction to the coil FSM's direction input
busy  output  1  move in progress
done  output  1  one-cycle pulse when a move completes normally
remaining  output  CNT_W  steps not yet issued

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; enable=0, direction=0, busy=0, done=0, remaining=0; interval counter=0. Takes effect immediately mid-move; no further pulses are issued.
- All outputs are registered.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 and abort=0: latch dir_in into direction, step_count into remaining, and max(period,1) into an internal interval register.
  - If step_count=0: go to FINISH (no enable pulse).
  - Otherwise: load the interval counter with interval-1 and go to RUN.
  - start=1 with abort=1 in the same cycle: abort wins and start is ignored.
- RUN:
  - busy=1.
  - Interval counter decrements each cycle.
  - When it is 0: enable=1 for the next cycle only, remaining decrements by 1, and the counter reloads with interval-1.
  - Timing: the first enable is high exactly `interval` cycles after the start edge. Consecutive enables rise `interval` cycles apart. With interval=1, enable stays high for step_count consecutive cycles.
  - When the pulse that takes remaining to 0 is issued: go to FINISH.
  - start is ignored in RUN.
  - direction, the interval register and the latched count do not change during a move.
- FINISH: done=1 for one cycle, busy=0, enable=0, then go to IDLE. A start arriving in the FINISH cycle is ignored.
- Abort in RUN: next edge goes to IDLE with enable=0, busy=0 and done never asserted. remaining holds the count of unissued steps. direction holds its value.
- Abort in the same cycle the counter hits 0: abort wins and no pulse is issued.
- Counter arithmetic is unsigned. remaining never decrements below 0.
- `direction` is valid whenever enable=1 (it is required by the downstream FSM).

Optional Feature:
STEP_RAMP_EN
- Defined: the first min(RAMP_STEPS, step_count) steps of each move use interval 2*max(period,1). Later steps use max(period,1). The doubled interval saturates at 2^PER_W-1. The soft start prevents stall on motor spin-up.
- Undefined: every step uses max(period,1). RAMP_STEPS is unused and there is no extra logic.

Decomposition:
- Package stepper_pkg holds:
  - the state enum (IDLE, RUN, FINISH);
  - CNT_W and PER_W defaults;
  - constants DIR_FWD=1 and DIR_REV=0, shared with the coil FSM.
- One sub-module, step_interval_timer: a loadable down-counter with a terminal-count pulse output and a reload input, PER_W wide. The top-level FSM, step counter and ramp logic stay in step_pulse_gen.

Test Plan:
- Normal move: reset release; start with step_count=3, period=4, dir_in=1 -> enable high on cycles 4, 8 and 12 after start; direction=1 throughout; busy from cycle 1; done high in cycle 13; remaining 3→2→1→0.
- Zero-length and period-0 moves:
  - step_count=0, period=5 -> no enable; done pulse on the cycle after start; busy never set.
  - step_count=2, period=0 -> behaves as period=1; enable high for 2 consecutive cycles.
- Abort mid-move: step_count=10, period=2; abort after 3 pulses -> no further enable; done stays 0; remaining=7; busy drops next edge.
- Abort collisions: start and abort in the same IDLE cycle -> stays IDLE. A new start during RUN or FINISH -> ignored; count and direction unchanged.
- Asynchronous reset: reset=0 mid-move, not aligned to a clock edge -> all outputs 0 immediately. After release, a fresh start with dir_in=0 gives direction=0.
- Ramp (STEP_RAMP_EN defined): step_count=6, period=3, RAMP_STEPS=4 -> pulse gaps 6,6,6,6,3,3 cycles. With the macro undefined, all gaps are 3.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper motion path (sequencer and coil FSM).
package stepper_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int PER_W_DEF = 20;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/step_interval_timer.sv
// Loadable down-counter; tc_o flags the zero count while running and the
// counter reloads itself from reload_i on that same cycle.
module step_interval_timer
  import stepper_pkg::*;
#(
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [PER_W-1:0] reload_i,
  output logic             tc_o
);

  logic [PER_W-1:0] cnt_q, cnt_d;

  assign tc_o = run_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || tc_o) begin
      cnt_d = reload_i;
    end else if (run_i) begin
      cnt_d = cnt_q - PER_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Move sequencer: one enable pulse per step at a programmable interval, then done.
// Optional soft-start ramp (doubled interval for the first steps): STEP_RAMP_EN.
module step_pulse_gen
  import stepper_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PER_W      = PER_W_DEF,
  parameter int RAMP_STEPS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] step_count,
  input  logic [PER_W-1:0] period,
  output logic             enable,
  output logic             direction,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  state_e           state_q, state_d;
  logic [PER_W-1:0] interval_q, interval_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             dir_q, dir_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             start_ok;
  logic             pulse;
  logic [PER_W-1:0] start_iv;
  logic [PER_W-1:0] first_iv;
  logic [PER_W-1:0] next_iv;
  logic             tmr_load;
  logic             tmr_run;
  logic             tmr_tc;
  logic [PER_W-1:0] tmr_val;

  assign start_ok = start && !abort;
  assign start_iv = (period == '0) ? PER_W'(1) : period;
  // Abort on the terminal-count cycle suppresses the pulse.
  assign pulse    = (state_q == RUN) && tmr_tc && !abort;
  assign tmr_load = (state_q == IDLE) && start_ok && (step_count != '0);
  assign tmr_run  = (state_q == RUN);
  assign tmr_val  = (state_q == IDLE) ? (first_iv - PER_W'(1)) : (next_iv - PER_W'(1));

`ifdef STEP_RAMP_EN
  logic [CNT_W-1:0] ramp_left_q, ramp_left_d;

  function automatic logic [PER_W-1:0] sat_dbl(input logic [PER_W-1:0] v);
    logic [PER_W:0] w;
    w = {v, 1'b0};
    return w[PER_W] ? '1 : w[PER_W-1:0];
  endfunction

  // ramp_left_q counts ramp steps not yet issued; reload value is for the step after this pulse.
  always_comb begin
    first_iv    = (RAMP_STEPS > 0) ? sat_dbl(start_iv) : start_iv;
    next_iv     = (ramp_left_q > CNT_W'(1)) ? sat_dbl(interval_q) : interval_q;
    ramp_left_d = ramp_left_q;
    if (tmr_load) begin
      ramp_left_d = CNT_W'(RAMP_STEPS);
    end else if (pulse && (ramp_left_q != '0)) begin
      ramp_left_d = ramp_left_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ramp_left_q <= '0;
    end else begin
      ramp_left_q <= ramp_left_d;
    end
  end
`else
  assign first_iv = start_iv;
  assign next_iv  = interval_q;
`endif

  step_interval_timer #(
    .PER_W (PER_W)
  ) u_timer (
    .clk_i    (clock),
    .rst_ni   (reset),
    .load_i   (tmr_load),
    .run_i    (tmr_run),
    .reload_i (tmr_val),
    .tc_o     (tmr_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = (step_count == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_tc && (remaining_q == CNT_W'(1))) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    interval_d  = interval_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    enable_d    = 1'b0;
    busy_d      = (state_d == RUN);
    done_d      = (state_q == FINISH);
    if ((state_q == IDLE) && start_ok) begin
      interval_d  = start_iv;
      remaining_d = step_count;
      dir_d       = dir_in;
    end
    if (pulse) begin
      enable_d = 1'b1;
      if (remaining_q != '0) begin
        remaining_d = remaining_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      interval_q  <= '0;
      remaining_q <= '0;
      dir_q       <= DIR_REV;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      interval_q  <= interval_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign enable    = enable_q;
  assign direction = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule
